// File: rtl/sm83_alu_if.sv
// Operand, flag and result bundle between the SM83 datapath sequencer and its ALU.
// The sequencer drives the master side; the ALU sits on the slave side.
interface sm83_alu_if;
  logic       carry_capture;
  logic       use_latched_carry;
  logic [4:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_flag_in;
  logic [2:0] alu_bit_index;
  logic [7:0] alu_out;
  logic [3:0] alu_flag_out;
  logic       latched_carry;

  modport master (
    output carry_capture, use_latched_carry, alu_op, alu_a, alu_b,
           alu_flag_in, alu_bit_index,
    input  alu_out, alu_flag_out, latched_carry
  );

  modport slave (
    input  carry_capture, use_latched_carry, alu_op, alu_a, alu_b,
           alu_flag_in, alu_bit_index,
    output alu_out, alu_flag_out, latched_carry
  );
endinterface

// File: rtl/sm83_alu.sv
// SM83 8-bit ALU: combinational result and flags, plus one latched carry bit that
// chains the low-byte add into the high-byte add for 16-bit address arithmetic.
module sm83_alu (
  input logic       clk,
  input logic       reset,
  sm83_alu_if.slave bus
);
  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADC   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_SBC   = 5'b00011;
  localparam logic [4:0] OP_AND   = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_CP    = 5'b00111;
  localparam logic [4:0] OP_RLCA  = 5'b01000;
  localparam logic [4:0] OP_RRCA  = 5'b01001;
  localparam logic [4:0] OP_RLA   = 5'b01010;
  localparam logic [4:0] OP_RRA   = 5'b01011;
  localparam logic [4:0] OP_DAA   = 5'b01100;
  localparam logic [4:0] OP_CPL   = 5'b01101;
  localparam logic [4:0] OP_SCF   = 5'b01110;
  localparam logic [4:0] OP_CCF   = 5'b01111;
  localparam logic [4:0] OP_RLC   = 5'b10000;
  localparam logic [4:0] OP_RRC   = 5'b10001;
  localparam logic [4:0] OP_RL    = 5'b10010;
  localparam logic [4:0] OP_RR    = 5'b10011;
  localparam logic [4:0] OP_SLA   = 5'b10100;
  localparam logic [4:0] OP_SRA   = 5'b10101;
  localparam logic [4:0] OP_SWAP  = 5'b10110;
  localparam logic [4:0] OP_SRL   = 5'b10111;
  localparam logic [4:0] OP_COPYA = 5'b11000;
  localparam logic [4:0] OP_COPYB = 5'b11001;
  localparam logic [4:0] OP_INCB  = 5'b11010;
  localparam logic [4:0] OP_DECB  = 5'b11011;
  localparam logic [4:0] OP_BIT   = 5'b11101;
  localparam logic [4:0] OP_RES   = 5'b11110;
  localparam logic [4:0] OP_SET   = 5'b11111;

  logic       latched_carry_q;
  logic       cin;
  logic       c_arith;
  logic [3:0] fi;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] bit_mask;
  logic [8:0] sum9;
  logic [4:0] sum5;
  logic [8:0] diff9;
  logic [4:0] diff5;
  logic [7:0] res;
  logic [3:0] fo;
  logic [7:0] daa_corr;
  logic       daa_c;

  assign a        = bus.alu_a;
  assign b        = bus.alu_b;
  assign cin      = bus.use_latched_carry ? latched_carry_q : bus.alu_flag_in[0];
  assign fi       = {bus.alu_flag_in[3:1], cin};
  assign c_arith  = ((bus.alu_op == OP_ADC) || (bus.alu_op == OP_SBC)) ? cin : 1'b0;
  assign bit_mask = 8'h01 << bus.alu_bit_index;

  // Nine/five-bit widths expose carry and borrow out of bits 7 and 3.
  assign sum9  = {1'b0, a} + {1'b0, b} + {8'h00, c_arith};
  assign sum5  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, c_arith};
  assign diff9 = {1'b0, a} - {1'b0, b} - {8'h00, c_arith};
  assign diff5 = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, c_arith};

  always_comb begin
    res      = a;
    fo       = fi;
    daa_corr = 8'h00;
    daa_c    = cin;
    case (bus.alu_op)
      OP_ADD, OP_ADC: begin
        res = sum9[7:0];
        fo  = {res == 8'h00, 1'b0, sum5[4], sum9[8]};
      end
      OP_SUB, OP_SBC, OP_CP: begin
        res = (bus.alu_op == OP_CP) ? a : diff9[7:0];
        fo  = {diff9[7:0] == 8'h00, 1'b1, diff5[4], diff9[8]};
      end
      OP_AND: begin
        res = a & b;
        fo  = {res == 8'h00, 3'b010};
      end
      OP_XOR: begin
        res = a ^ b;
        fo  = {res == 8'h00, 3'b000};
      end
      OP_OR: begin
        res = a | b;
        fo  = {res == 8'h00, 3'b000};
      end
      OP_RLCA, OP_RLC: begin
        res = {a[6:0], a[7]};
        fo  = {bus.alu_op[4] & (res == 8'h00), 2'b00, a[7]};
      end
      OP_RRCA, OP_RRC: begin
        res = {a[0], a[7:1]};
        fo  = {bus.alu_op[4] & (res == 8'h00), 2'b00, a[0]};
      end
      OP_RLA, OP_RL: begin
        res = {a[6:0], cin};
        fo  = {bus.alu_op[4] & (res == 8'h00), 2'b00, a[7]};
      end
      OP_RRA, OP_RR: begin
        res = {cin, a[7:1]};
        fo  = {bus.alu_op[4] & (res == 8'h00), 2'b00, a[0]};
      end
      OP_DAA: begin
        if (!fi[2]) begin
          if (cin || (a > 8'h99)) begin
            daa_corr[6:5] = 2'b11;
            daa_c         = 1'b1;
          end
          if (fi[1] || (a[3:0] > 4'd9)) daa_corr[2:1] = 2'b11;
          res = a + daa_corr;
        end else begin
          if (cin)   daa_corr[6:5] = 2'b11;
          if (fi[1]) daa_corr[2:1] = 2'b11;
          res = a - daa_corr;
        end
        fo = {res == 8'h00, fi[2], 1'b0, daa_c};
      end
      OP_CPL: begin
        res = ~a;
        fo  = {fi[3], 2'b11, fi[0]};
      end
      OP_SCF: fo = {fi[3], 3'b001};
      OP_CCF: fo = {fi[3], 2'b00, ~cin};
      OP_SLA: begin
        res = {a[6:0], 1'b0};
        fo  = {res == 8'h00, 2'b00, a[7]};
      end
      OP_SRA: begin
        res = {a[7], a[7:1]};
        fo  = {res == 8'h00, 2'b00, a[0]};
      end
      OP_SWAP: begin
        res = {a[3:0], a[7:4]};
        fo  = {res == 8'h00, 3'b000};
      end
      OP_SRL: begin
        res = {1'b0, a[7:1]};
        fo  = {res == 8'h00, 2'b00, a[0]};
      end
      OP_COPYA: res = a;
      OP_COPYB: res = b;
      OP_INCB: begin
        res = b + 8'h01;
        fo  = {res == 8'h00, 1'b0, b[3:0] == 4'hF, fi[0]};
      end
      OP_DECB: begin
        res = b - 8'h01;
        fo  = {res == 8'h00, 1'b1, b[3:0] == 4'h0, fi[0]};
      end
      OP_BIT: fo  = {(a & bit_mask) == 8'h00, 2'b01, fi[0]};
      OP_RES: res = a & ~bit_mask;
      OP_SET: res = a | bit_mask;
      default: begin
        res = a;
        fo  = fi;
      end
    endcase
  end

  // The comb path above always sees the pre-edge value, so capture and use can overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 latched_carry_q <= 1'b0;
    else if (bus.carry_capture) latched_carry_q <= fo[0];
  end

  assign bus.alu_out       = res;
  assign bus.alu_flag_out  = fo;
  assign bus.latched_carry = latched_carry_q;
endmodule

// File: tb/tb_sm83_alu.sv
// Self-checking bench for sm83_alu: directed vector table, latched-carry sequences,
// and randomized operations against an integer-arithmetic reference model.
module tb_sm83_alu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sm83_alu_if bus ();
  sm83_alu dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
    logic [2:0] idx;
    logic [7:0] eo;
    logic [3:0] ef;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the documented rules; returns {out, Z N H C}.
  function automatic logic [11:0] model(input int op, input int a, input int b,
                                        input int f, input int idx, input int cin);
    int r, z, n, h, c, t;
    z = (f >> 3) & 1; n = (f >> 2) & 1; h = (f >> 1) & 1; c = cin; r = a;
    case (op)
      0, 1: begin
        t = (op == 1) ? cin : 0;
        r = a + b + t; h = ((a % 16) + (b % 16) + t) > 15; c = r > 255;
        r = r % 256; z = (r == 0); n = 0;
      end
      2, 3, 7: begin
        t = (op == 3) ? cin : 0;
        r = a - b - t; h = ((a % 16) - (b % 16) - t) < 0; c = r < 0;
        r = (r + 256) % 256; z = (r == 0); n = 1;
        if (op == 7) r = a;
      end
      4: begin r = a & b; z = (r == 0); n = 0; h = 1; c = 0; end
      5: begin r = a ^ b; z = (r == 0); n = 0; h = 0; c = 0; end
      6: begin r = a | b; z = (r == 0); n = 0; h = 0; c = 0; end
      8, 16:  begin c = a / 128; r = (a * 2) % 256 + c; end
      9, 17:  begin c = a % 2;   r = a / 2 + c * 128; end
      10, 18: begin c = a / 128; r = (a * 2) % 256 + cin; end
      11, 19: begin c = a % 2;   r = a / 2 + cin * 128; end
      12: begin
        if (n == 0) begin
          if (cin == 1 || a > 153) begin r = r + 96; c = 1; end
          if (h == 1 || (a % 16) > 9) r = r + 6;
        end else begin
          if (cin == 1) r = r - 96;
          if (h == 1)   r = r - 6;
        end
        r = (r + 512) % 256; z = (r == 0); h = 0;
      end
      13: begin r = 255 - a; n = 1; h = 1; end
      14: begin n = 0; h = 0; c = 1; end
      15: begin n = 0; h = 0; c = (cin == 0); end
      20: begin c = a / 128; r = (a * 2) % 256; end
      21: begin c = a % 2; r = a / 2 + (a / 128) * 128; end
      22: begin c = 0; r = (a % 16) * 16 + a / 16; end
      23: begin c = a % 2; r = a / 2; end
      25: r = b;
      26: begin r = (b + 1) % 256; z = (r == 0); n = 0; h = ((b % 16) == 15); end
      27: begin r = (b + 255) % 256; z = (r == 0); n = 1; h = ((b % 16) == 0); end
      29: begin z = (((a >> idx) & 1) == 0); n = 0; h = 1; end
      30: r = (((a >> idx) & 1) == 1) ? a - (1 << idx) : a;
      31: r = a | (1 << idx);
      default: r = a;
    endcase
    if (op >= 8 && op <= 11) begin z = 0; n = 0; h = 0; end
    if (op >= 16 && op <= 23) begin z = (r == 0); n = 0; h = 0; end
    return {8'(r), 1'(z), 1'(n), 1'(h), 1'(c)};
  endfunction

  task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f, input logic [2:0] idx, input logic use_lc,
                       input logic cap);
    bus.alu_op = op; bus.alu_a = a; bus.alu_b = b; bus.alu_flag_in = f;
    bus.alu_bit_index = idx; bus.use_latched_carry = use_lc; bus.carry_capture = cap;
  endtask

  initial begin
    logic       lc_m;
    logic [11:0] exp_v;
    int         cin_m;

    vt[0]  = '{"add",   5'b00000, 8'h3A, 8'hC6, 4'b0000, 3'd0, 8'h00, 4'b1011};
    vt[1]  = '{"adc",   5'b00001, 8'h3A, 8'hC6, 4'b0001, 3'd0, 8'h01, 4'b0011};
    vt[2]  = '{"sub",   5'b00010, 8'h3E, 8'h3F, 4'b0000, 3'd0, 8'hFF, 4'b0111};
    vt[3]  = '{"cp",    5'b00111, 8'h3C, 8'h3C, 4'b0000, 3'd0, 8'h3C, 4'b1100};
    vt[4]  = '{"daa_n0",5'b01100, 8'h9A, 8'h00, 4'b0000, 3'd0, 8'h00, 4'b1001};
    vt[5]  = '{"daa_n1",5'b01100, 8'h45, 8'h00, 4'b0110, 3'd0, 8'h3F, 4'b0100};
    vt[6]  = '{"rlca",  5'b01000, 8'h85, 8'h00, 4'b0000, 3'd0, 8'h0B, 4'b0001};
    vt[7]  = '{"swap",  5'b10110, 8'hF0, 8'h00, 4'b0000, 3'd0, 8'h0F, 4'b0000};
    vt[8]  = '{"sra",   5'b10101, 8'h81, 8'h00, 4'b0000, 3'd0, 8'hC0, 4'b0001};
    vt[9]  = '{"bit7",  5'b11101, 8'h7F, 8'h00, 4'b0001, 3'd7, 8'h7F, 4'b1011};
    vt[10] = '{"set0",  5'b11111, 8'h00, 8'h00, 4'b0000, 3'd0, 8'h01, 4'b0000};
    vt[11] = '{"incb",  5'b11010, 8'h00, 8'hFF, 4'b0001, 3'd0, 8'h00, 4'b1011};
    vt[12] = '{"decb",  5'b11011, 8'h00, 8'h10, 4'b0000, 3'd0, 8'h0F, 4'b0110};
    vt[13] = '{"ccf",   5'b01111, 8'h55, 8'h00, 4'b1001, 3'd0, 8'h55, 4'b1000};
    vt[14] = '{"rra_z", 5'b01011, 8'h01, 8'h00, 4'b0000, 3'd0, 8'h00, 4'b0001};

    drive(5'd0, 8'h00, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    #12;
    chk("reset_lc", {11'h0, bus.latched_carry}, 12'h000);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].f, vt[i].idx, 1'b0, 1'b0);
      #1;
      chk(vt[i].name, {bus.alu_out, bus.alu_flag_out}, {vt[i].eo, vt[i].ef});
    end

    // 16-bit address chain: capture low-byte carry, consume it in the high byte.
    @(negedge clk);
    drive(5'b00000, 8'hF0, 8'h20, 4'b0000, 3'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("lc_capture", {11'h0, bus.latched_carry}, 12'h001);
    drive(5'b00001, 8'h12, 8'h00, 4'b0000, 3'd0, 1'b1, 1'b0);
    #1;
    chk("adc_lc", {bus.alu_out, bus.alu_flag_out}, {8'h13, 4'b0000});
    @(posedge clk); #1;
    chk("lc_hold", {11'h0, bus.latched_carry}, 12'h001);
    // Capture and use together: result sees old carry, new carry (0) stored.
    drive(5'b00001, 8'h01, 8'h01, 4'b0000, 3'd0, 1'b1, 1'b1);
    #1;
    chk("adc_lc_old", {bus.alu_out, bus.alu_flag_out}, {8'h03, 4'b0000});
    @(posedge clk); #1;
    chk("lc_newval", {11'h0, bus.latched_carry}, 12'h000);
    // Set it again, then assert reset asynchronously mid-cycle.
    drive(5'b01110, 8'h00, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("lc_scf", {11'h0, bus.latched_carry}, 12'h001);
    drive(5'b00001, 8'h12, 8'h00, 4'b0000, 3'd0, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("lc_async_rst", {11'h0, bus.latched_carry}, 12'h000);
    chk("adc_after_rst", {bus.alu_out, bus.alu_flag_out}, {8'h12, 4'b0000});
    @(posedge clk); #1;
    chk("rst_beats_cap", {11'h0, bus.latched_carry}, 12'h000);
    @(negedge clk);
    reset = 1'b1;
    lc_m = 1'b0;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(5'($urandom_range(31)), 8'($urandom), 8'($urandom), 4'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom));
      cin_m = bus.use_latched_carry ? int'(lc_m) : int'(bus.alu_flag_in[0]);
      exp_v = model(int'(bus.alu_op), int'(bus.alu_a), int'(bus.alu_b),
                    int'(bus.alu_flag_in), int'(bus.alu_bit_index), cin_m);
      #1;
      chk("rand_op", {bus.alu_out, bus.alu_flag_out}, exp_v);
      @(posedge clk); #1;
      if (bus.carry_capture) lc_m = exp_v[0];
      chk("rand_lc", {11'h0, bus.latched_carry}, {11'h0, lc_m});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm83_alu.md
# sm83_alu

8-bit arithmetic/logic unit for the SM83 (Game Boy) CPU datapath. It evaluates every 8-bit ALU, accumulator/flag, CB-prefix rotate/shift/bit, copy and increment/decrement operation combinationally from a 5-bit inner opcode, two operands and the incoming flag nibble. A single clocked bit, the latched carry, chains the low-byte add into the high-byte add for 16-bit address arithmetic.

## Interface
- No parameters.
- `clk` input 1: system clock; the latched carry updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears the latched carry.
- `carry_capture` input 1: when high at a rising `clk` edge, store `alu_flag_out[0]` into the latched carry.
- `use_latched_carry` input 1: replace `alu_flag_in[0]` with the latched carry as the effective carry-in.
- `alu_op` input 5: inner opcode.
- `alu_a` input 8: operand A.
- `alu_b` input 8: operand B.
- `alu_flag_in` input 4: current flags. Bit 3 Z, bit 2 N, bit 1 H, bit 0 C.
- `alu_bit_index` input 3: bit number for BIT/RES/SET.
- `alu_out` output 8: result (combinational).
- `alu_flag_out` output 4: next flags (combinational). Same bit order as `alu_flag_in`.
- `latched_carry` output 1: current latched carry; 0 after reset.

## Operation
- Fi is `alu_flag_in` with bit 0 replaced by the effective carry `cin`. Z means result==0. Any flag not listed passes through from Fi.
- 00000 ADD: a+b. Z, N=0, H=carry out of bit 3, C=carry out of bit 7.
- 00001 ADC: a+b+cin. Flags as ADD, with cin included in H and C.
- 00010 SUB: a−b. Z, N=1, H=(a[3:0]<b[3:0]), C=(a<b).
- 00011 SBC: a−b−cin. Flags as SUB, borrows include cin.
- 00100 AND: Z, N=0, H=1, C=0.
- 00101 XOR and 00110 OR: Z, N=0, H=0, C=0.
- 00111 CP: flags as SUB; out = a.
- 01000 RLCA, 01001 RRCA, 01010 RLA, 01011 RRA: rotate a (RLA/RRA go through cin). Z=0, N=0, H=0, C=bit shifted out.
- 01100 DAA:
  - N=0: add 0x60 and set C if cin or a>0x99; add 0x06 if H or a[3:0]>9.
  - N=1: subtract 0x60 if cin; subtract 0x06 if H.
  - Flags: Z, N unchanged, H=0, C as computed (otherwise cin).
- 01101 CPL: out=~a, N=1, H=1.
- 01110 SCF: out=a, N=0, H=0, C=1.
- 01111 CCF: out=a, N=0, H=0, C=!cin.
- 10000–10111 RLC, RRC, RL, RR, SLA, SRA, SWAP, SRL on a:
  - RL/RR use cin; SRA keeps bit 7.
  - Z, N=0, H=0, C=bit shifted out (SWAP: C=0).
- 11000 COPYA: out=a, flags Fi.
- 11001 COPYB: out=b, flags Fi.
- 11010 INCB: out=b+1. Z, N=0, H=(b[3:0]==0xF), C unchanged.
- 11011 DECB: out=b−1. Z, N=1, H=(b[3:0]==0), C unchanged.
- 11101 BIT: out=a, Z=!a[idx], N=0, H=1, C unchanged.
- 11110 RES: out = a with bit idx cleared; flags Fi.
- 11111 SET: out = a with bit idx set; flags Fi.
- 11100 (unused): out=a, flags Fi.
- All arithmetic is modulo 256.

## Timing
- `alu_out` and `alu_flag_out` are purely combinational, with zero latency from any input, including `latched_carry` when `use_latched_carry`=1.
- `latched_carry` updates only on a `clk` rising edge with `carry_capture`=1. It holds otherwise.
- `reset` low clears `latched_carry` to 0 immediately and asynchronously, regardless of `clk`. Reset wins over a simultaneous capture.
- Capture and use in the same cycle: the combinational result uses the old latched value, and the new value is stored at the edge.

## Test plan
- ADD a=0x3A, b=0xC6 -> out=0x00, flags Z1 N0 H1 C1. ADC same operands with C=1 -> out=0x01, flags 0011.
- SUB a=0x3E, b=0x3F -> out=0xFF, flags 0111. CP a=0x3C, b=0x3C -> out=0x3C, flags 1100.
- DAA:
  - a=0x9A, N=0, H=0, C=0 -> out=0x00, Z=1, C=1.
  - a=0x45 after a subtract (N=1, H=1) -> out=0x3F.
- Rotates and bit ops:
  - RLCA a=0x85 -> out=0x0B, flags 0001.
  - SWAP a=0xF0 -> 0x0F, flags 0000.
  - SRA a=0x81 -> 0xC0, C=1.
  - BIT idx=7, a=0x7F -> Z=1, H=1, C kept.
  - SET idx=0, a=0x00 -> 0x01.
- INCB b=0xFF, C=1 -> out=0x00, flags 1011. DECB b=0x10 -> out=0x0F, flags 0110 with C=0.
- Latched carry:
  - ADD a=0xF0, b=0x20 with capture at the edge -> latched_carry=1.
  - Next cycle: ADC with use_latched_carry, a=0x12, b=0x00, flag_in C=0 -> out=0x13.
  - Drive reset low mid-cycle -> latched_carry=0 immediately.
